// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM stream reader.
package bram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rd_state_t;

    localparam int unsigned FIFO_DEPTH = 4;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready stream carrying memory words plus an end-of-transfer marker.
interface bram_stream_reader_if #(
    parameter int unsigned BIT_LENGTH = 64
) ();

    logic [BIT_LENGTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/stream_fifo.sv
// Small synchronous FIFO; head entry is presented on dout_o while not empty.
module stream_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [OCC_W-1:0] occ_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [OCC_W-1:0] occ_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop_i) begin
                rd_q <= ptr_inc(rd_q);
            end
            occ_q <= occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign occ_o   = occ_q;
    assign empty_o = (occ_q == '0);

endmodule

// File: rtl/bram_stream_reader.sv
// Reads len words from a registered-output memory port and streams them out,
// prefetching into a small FIFO so a word per cycle is sustained.
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int unsigned BIT_LENGTH = 64,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned LEN_W     = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [AW-1:0]         base_addr_i,
    input  logic [LEN_W-1:0]      len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [AW-1:0]         addrb_o,
    output logic                  enb_o,
    input  logic [BIT_LENGTH-1:0] doutb_i,
    bram_stream_reader_if.master  m_if
);

    localparam int unsigned FW    = BIT_LENGTH + 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CW    = OCC_W + 1;

    rd_state_t        state_q, state_d;
    logic [AW-1:0]    base_q, base_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             enb_q, enb_d;
    logic             enb_last_q, enb_last_d;
    logic             rd_vld_q, rd_last_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [FW-1:0]    fifo_dout;
    logic [OCC_W-1:0] fifo_occ;
    logic             fifo_empty;
    logic             pop_c;
    logic [CW-1:0]    load_c;

    assign pop_c = ~fifo_empty & m_if.m_ready;
    // Words that will occupy the FIFO next cycle: stored + landing now + read issued now.
    assign load_c = CW'(fifo_occ) + CW'(rd_vld_q) + CW'(enb_q) - CW'(pop_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            addr_q     <= '0;
            enb_q      <= 1'b0;
            enb_last_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            addr_q     <= addr_d;
            enb_q      <= enb_d;
            enb_last_q <= enb_last_d;
            rd_vld_q   <= enb_q;
            rd_last_q  <= enb_last_q;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        issued_d   = issued_q + LEN_W'(enb_q);
        addr_d     = addr_q;
        enb_d      = 1'b0;
        enb_last_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                issued_d = '0;
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d = READ;
                        base_d  = base_addr_i;
                        len_d   = len_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issued_d == len_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_c && m_if.m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Issue decision for next cycle so enb/addrb leave flops.
        if (state_d == READ && issued_d < len_d && load_c < CW'(FIFO_DEPTH)) begin
            enb_d      = 1'b1;
            addr_d     = base_d + AW'(issued_d);
            enb_last_d = (issued_d == len_d - LEN_W'(1));
        end
        busy_d = (state_d != IDLE);
    end

    stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rd_vld_q),
        .din_i   ({rd_last_q, doutb_i}),
        .pop_i   (pop_c),
        .dout_o  (fifo_dout),
        .occ_o   (fifo_occ),
        .empty_o (fifo_empty)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign addrb_o     = addr_q;
    assign enb_o       = enb_q;
    assign m_if.m_valid = ~fifo_empty;
    assign m_if.m_data  = fifo_dout[BIT_LENGTH-1:0];
    assign m_if.m_last  = fifo_dout[BIT_LENGTH] & ~fifo_empty;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed plus randomized bench for bram_stream_reader against a
// word-list model of a preloaded memory.
module tb_bram_stream_reader;

    localparam int unsigned BL    = 64;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [AW:0]   len_i;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] addrb_o;
    logic          enb_o;
    logic [BL-1:0] doutb;
    logic [BL-1:0] mem [DEPTH];

    int total = 0;
    int bad   = 0;

    bram_stream_reader_if #(.BIT_LENGTH(BL)) s_if ();

    bram_stream_reader #(
        .BIT_LENGTH (BL),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .addrb_o     (addrb_o),
        .enb_o       (enb_o),
        .doutb_i     (doutb),
        .m_if        (s_if)
    );

    always #5 clk = ~clk;

    // Memory port B: one-cycle registered read.
    always @(posedge clk) begin
        if (enb_o) doutb <= mem[addrb_o];
    end

    function automatic logic [BL-1:0] exp_word(input int a);
        return BL'(a % DEPTH) * 64'h11;
    endfunction

    task automatic chk(input string tag, input logic [BL:0] obs, input logic [BL:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},  BL'(busy_o), 0);
        chk({tag, "_done"},  BL'(done_o), 0);
        chk({tag, "_enb"},   BL'(enb_o), 0);
        chk({tag, "_addrb"}, BL'(addrb_o), 0);
        chk({tag, "_valid"}, BL'(s_if.m_valid), 0);
        chk({tag, "_last"},  BL'(s_if.m_last), 0);
        chk({tag, "_data"},  {1'b0, s_if.m_data}, 0);
    endtask

    // One transfer; cycle n is sampled 1 time unit after the n-th edge following start.
    task automatic xfer(input int base, input int len, input bit rnd_ready, input int stall);
        int n_enb   = 0;
        int n_pop   = 0;
        int cyc     = 1;
        int first_v = -1;
        int last_hs = -1;
        bit fin     = 1'b0;
        bit pv      = 1'b0;
        bit pr      = 1'b0;
        logic          pl = 1'b0;
        logic [BL-1:0] pd = '0;
        start_i     = 1'b1;
        base_addr_i = AW'(base);
        len_i       = (AW + 1)'(len);
        s_if.m_ready = ~rnd_ready;
        @(posedge clk); #1;
        start_i = 1'b0;
        if (len == 0) begin
            chk("zero_done", BL'(done_o), 1);
            chk("zero_busy", BL'(busy_o), 0);
            chk("zero_enb",  BL'(enb_o), 0);
            repeat (5) begin
                @(posedge clk); #1;
                chk("zero_quiet", BL'({busy_o, done_o, enb_o, s_if.m_valid}), 0);
            end
            return;
        end
        chk("first_enb",  BL'(enb_o), 1);
        chk("first_busy", BL'(busy_o), 1);
        while (!fin && cyc < 400) begin
            if (enb_o) begin
                chk("enb_addr", BL'(addrb_o), BL'((base + n_enb) % DEPTH));
                n_enb++;
            end
            chk("outstanding", BL'((n_enb - n_pop <= 4) && (n_enb <= len)), 1);
            if (pv && !pr)
                chk("stall_hold", {s_if.m_valid, s_if.m_data}, {1'b1, pd});
            if (pv && !pr)
                chk("stall_last", BL'(s_if.m_last), BL'(pl));
            if (done_o) begin
                chk("done_count", BL'(n_pop), BL'(len));
                chk("done_after_last", BL'(cyc), BL'(last_hs + 1));
                chk("done_busy", BL'(busy_o), 0);
                if (!rnd_ready) begin
                    chk("first_valid_cycle", BL'(first_v), 3);
                    chk("back_to_back", BL'(last_hs), BL'(first_v + len - 1));
                end
                fin = 1'b1;
            end else begin
                s_if.m_ready = rnd_ready ? (cyc > stall && $urandom_range(0, 2) != 0) : 1'b1;
                if (s_if.m_valid) begin
                    if (first_v < 0) first_v = cyc;
                    chk("no_extra_word", BL'(n_pop < len), 1);
                    chk("data", {1'b0, s_if.m_data}, {1'b0, exp_word(base + n_pop)});
                    chk("last", BL'(s_if.m_last), BL'(n_pop == len - 1));
                    if (s_if.m_ready) begin
                        n_pop++;
                        if (n_pop == len) last_hs = cyc;
                    end
                end
                pv = s_if.m_valid;
                pr = s_if.m_ready;
                pd = s_if.m_data;
                pl = s_if.m_last;
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("finished_in_time", BL'(fin), 1);
        chk("enb_count", BL'(n_enb), BL'(len));
        @(posedge clk); #1;
        chk("post_idle", BL'({s_if.m_valid, busy_o, done_o, enb_o}), 0);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = exp_word(i);
        rst = 1'b1;
        start_i = 1'b0;
        base_addr_i = '0;
        len_i = '0;
        s_if.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        xfer(3, 5, 1'b0, 0);
        xfer(14, 4, 1'b0, 0);
        xfer(0, 16, 1'b1, 10);
        xfer(0, 0, 1'b0, 0);
        xfer(0, 16, 1'b0, 0);
        xfer(7, 1, 1'b0, 0);

        // Ignored restart while busy, then reset mid-transfer.
        s_if.m_ready = 1'b1;
        start_i = 1'b1;
        base_addr_i = AW'(2);
        len_i = (AW + 1)'(8);
        @(posedge clk); #1;
        for (int c = 1; c <= 6; c++) begin
            if (c >= 3) chk("restart_data", {1'b0, s_if.m_data}, {1'b0, exp_word(c - 1)});
            if (c == 4) begin
                start_i = 1'b1;
                base_addr_i = AW'(9);
                len_i = (AW + 1)'(3);
            end else begin
                start_i = 1'b0;
            end
            rst = (c == 6);
            @(posedge clk); #1;
        end
        chk_reset("mid_reset");
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("after_reset_quiet", BL'({s_if.m_valid, enb_o, busy_o, done_o}), 0);
        end
        xfer(5, 2, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            xfer(int'($urandom_range(0, 15)), int'($urandom_range(1, 16)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
